// File: rtl/ftch_imem_pkg.sv
// Fetch-to-imem request types.
package ftch_imem_pkg;

    typedef struct packed {
        logic [31:0] pc;
    } ftch_imem_pkt_t;

endpackage

// File: rtl/imem_ftch_pkg.sv
// Imem-to-fetch response types and constants.
package imem_ftch_pkg;

    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err_misalign;
        logic        err_range;
    } imem_ftch_pkt_t;

    // True when a byte address is not word aligned.
    function automatic logic pc_misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/imem_ftch_intf.sv
// Signal bundle for the imem fetch-response block, with bench-side clocking views.
interface imem_ftch_intf #(
    parameter int unsigned IMEM_DEPTH = 1024
) (
    input logic clk
);
    import ftch_imem_pkg::*;
    import imem_ftch_pkg::*;

    logic                          resetn;
    logic                          ftch_imem_vld;
    ftch_imem_pkt_t                ftch_imem_pkt;
    logic                          ftch_flush;
    logic                          ld_en;
    logic [$clog2(IMEM_DEPTH)-1:0] ld_addr;
    logic [31:0]                   ld_data;
    logic                          imem_ftch_vld;
    imem_ftch_pkt_t                imem_ftch_pkt;

    clocking driver @(posedge clk);
        output ftch_imem_vld, ftch_imem_pkt, ftch_flush, ld_en, ld_addr, ld_data;
    endclocking

    clocking mon_cb @(posedge clk);
        input ftch_imem_vld, ftch_imem_pkt, ftch_flush, imem_ftch_vld, imem_ftch_pkt;
    endclocking

endinterface

// File: rtl/imem_ftch_ram.sv
// Single-port-read, single-port-write word RAM with registered read data.
// A read and write to the same word in one cycle returns the old contents.
module imem_ftch_ram #(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata
);

    logic [31:0] mem [DEPTH];

    // Synchronous read then write; non-blocking ordering gives read-before-write.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

endmodule

// File: rtl/imem_ftch_resp.sv
// Fixed-latency instruction memory: every accepted fetch returns one response
// IMEM_LAT cycles later, in order, with alignment and range errors flagged.
module imem_ftch_resp
    import ftch_imem_pkg::*;
    import imem_ftch_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter int unsigned IMEM_LAT   = 2
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          ftch_imem_vld,
    input  ftch_imem_pkt_t                ftch_imem_pkt,
    input  logic                          ftch_flush,
    input  logic                          ld_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] ld_addr,
    input  logic [31:0]                   ld_data,
    output logic                          imem_ftch_vld,
    output imem_ftch_pkt_t                imem_ftch_pkt
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic [29:0]         word_idx;
    logic                req_misalign;
    logic                req_range;
    logic                ram_re;
    logic [31:0]         ram_rdata;
    logic [IMEM_LAT-1:0] vld_q;
    logic [31:0]         s0_pc_q;
    logic                s0_misalign_q;
    logic                s0_range_q;
    imem_ftch_pkt_t      s0_pkt;

    // Request decode: word index, error checks, and gated array read.
    always_comb begin
        word_idx     = ftch_imem_pkt.pc[31:2];
        req_misalign = pc_misaligned(ftch_imem_pkt.pc);
        req_range    = |word_idx[29:AW];
        ram_re       = ftch_imem_vld & ~req_range;
    end

    imem_ftch_ram #(
        .DEPTH (IMEM_DEPTH)
    ) u_ram (
        .clk   (clk),
        .re    (ram_re),
        .raddr (word_idx[AW-1:0]),
        .rdata (ram_rdata),
        .we    (ld_en),
        .waddr (ld_addr),
        .wdata (ld_data)
    );

    // Stage valids: stage 0 always takes the new request; a flush drops all older stages.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= ftch_imem_vld;
            for (int k = 1; k < int'(IMEM_LAT); k++) begin
                vld_q[k] <= vld_q[k-1] & ~ftch_flush;
            end
        end
    end

    // Stage 0 request metadata, captured alongside the array read; not reset.
    always_ff @(posedge clk) begin
        if (ftch_imem_vld) begin
            s0_pc_q       <= ftch_imem_pkt.pc;
            s0_misalign_q <= req_misalign;
            s0_range_q    <= req_range;
        end
    end

    // Stage 0 packet: errored requests return a NOP instead of stale read data.
    always_comb begin
        s0_pkt              = '0;
        s0_pkt.pc           = s0_pc_q;
        s0_pkt.err_misalign = s0_misalign_q;
        s0_pkt.err_range    = s0_range_q;
        s0_pkt.instr        = (s0_misalign_q | s0_range_q) ? IMEM_NOP : ram_rdata;
    end

    if (IMEM_LAT > 1) begin : g_shift
        imem_ftch_pkt_t pkt_q [IMEM_LAT-1];

        // Later stages only shift the stage 0 packet forward; not reset.
        always_ff @(posedge clk) begin
            pkt_q[0] <= s0_pkt;
            for (int k = 1; k < int'(IMEM_LAT) - 1; k++) begin
                pkt_q[k] <= pkt_q[k-1];
            end
        end

        assign imem_ftch_pkt = pkt_q[IMEM_LAT-2];
    end else begin : g_direct
        assign imem_ftch_pkt = s0_pkt;
    end

    assign imem_ftch_vld = vld_q[IMEM_LAT-1];

endmodule

// File: doc/imem_ftch_resp.md
IMEM_FTCH_RESP -- requirements
Module: imem_ftch_resp

Interface
REQ-001 Parameter IMEM_DEPTH, default 1024, SHALL set instruction memory depth in 32-bit words (power of two, 16..65536).
REQ-002 Parameter IMEM_LAT, default 2, SHALL set request-to-response latency in cycles (legal 1..4).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on posedge clk.
REQ-004 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 ftch_imem_vld  input  1  SHALL be the fetch request valid; there is no ready, so a request SHALL be accepted every cycle it is high.
REQ-006 ftch_imem_pkt  input  ftch_imem_pkt_t  SHALL carry request byte address pc[31:0].
REQ-007 ftch_flush  input  1  SHALL be the fetch redirect; it kills all in-flight responses.
REQ-008 ld_en / ld_addr / ld_data  input  1 / $clog2(IMEM_DEPTH) / 32  SHALL form the backdoor word-write port used by bench and boot loader.
REQ-009 imem_ftch_vld  output  1  SHALL be the response valid.
REQ-010 imem_ftch_pkt  output  imem_ftch_pkt_t  SHALL carry pc, instr[31:0], err_misalign, err_range.

Function
REQ-011 Each accepted request SHALL produce exactly one response exactly IMEM_LAT cycles later, unless killed by flush or reset.
REQ-012 Responses SHALL return in request order; back-to-back requests every cycle SHALL give back-to-back responses with no bubbles.
REQ-013 Word index SHALL be pc[31:2]; the array read SHALL use the low $clog2(IMEM_DEPTH) bits only when the range check passes.
REQ-014 pc[1:0] != 0 SHALL set err_misalign=1, instr=32'h0000_0000.
REQ-015 pc[31:2] >= IMEM_DEPTH SHALL set err_range=1, instr=32'h0000_0000; both error flags MAY be set together.
REQ-016 Response pc SHALL equal the request pc unmodified.
REQ-017 ftch_flush high in cycle N SHALL clear every pipeline stage valid holding a request accepted before cycle N; imem_ftch_vld SHALL be 0 from cycle N+1 until the next surviving response.
REQ-018 A request accepted in the same cycle as ftch_flush SHALL survive and respond normally (flush kills only older traffic).
REQ-019 ld_en write and request read of the same word in the same cycle SHALL return the old data (read-before-write); the new data SHALL be visible to requests from the next cycle.
REQ-020 The pipeline SHALL be an IMEM_LAT-deep shift register of {vld, pkt}; stage 0 captures the array read, later stages only shift.
REQ-021 imem_ftch_pkt SHALL be don't-care when imem_ftch_vld=0, but SHALL NOT contain X when imem_ftch_vld=1.

Reset
REQ-022 resetn low SHALL immediately force imem_ftch_vld=0 and clear all stage valids, regardless of clock.
REQ-023 Stage data registers and memory contents SHALL NOT be reset; memory SHALL retain contents across reset.
REQ-024 Requests in flight when resetn asserts SHALL be discarded; the first request after resetn deassertion SHALL respond IMEM_LAT cycles later.

Structure
REQ-025 Package imem_ftch_pkg SHALL hold imem_ftch_pkt_t and constant IMEM_NOP=32'h0; ftch_imem_pkt_t stays in ftch_imem_pkg.
REQ-026 The storage array SHALL be one sub-module imem_ftch_ram (1 read, 1 write, synchronous read, read-before-write).
REQ-027 A matching imem_ftch_intf with mon_cb and driver clocking blocks SHALL be provided for the bench.

Verification
REQ-028 Load word 5=32'h2008_0001; request pc=0x14 with IMEM_LAT=2 -> vld at +2 cycles, instr=32'h2008_0001, both errors 0.
REQ-029 Requests pc=0x0,0x4,0x8 on consecutive cycles -> three consecutive responses, in order, pcs matching.
REQ-030 Request pc=0x16 -> err_misalign=1, instr=0; request pc=IMEM_DEPTH*4 -> err_range=1, instr=0.
REQ-031 Requests at cycles 0,1; flush at cycle 1 with new request pc=0x40 -> cycle-0 response killed, cycle-1 (pc=0x40) response delivered.
REQ-032 Same cycle ld_en word 3=32'hDEAD_BEEF and request pc=0xC (old 32'h1) -> response 32'h1; repeat request next cycle -> 32'hDEAD_BEEF.
REQ-033 Assert resetn low mid-stream with two requests in flight -> vld=0 immediately, no responses after release, memory contents unchanged.
